// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master and its clock divider.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        SHIFT = 2'd2,
        TRAIL = 2'd3
    } spi_state_t;

    // SPI mode numbers encoded as {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period down-counter: ticks when it reaches zero, then reloads from div.
module spi_clk_div #(
    parameter int DIV_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                en,
    input  logic [DIV_BITS-1:0] div,
    output logic                tick
);

    logic [DIV_BITS-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= div;
        end else if (en) begin
            cnt <= (cnt == '0) ? div : cnt - DIV_BITS'(1);
        end
    end

    assign tick = en && (cnt == '0);

endmodule

// File: rtl/spi_master_xfer.sv
// Full-duplex SPI master: one start strobe shifts a WIDTH-bit word out on mosi
// while capturing WIDTH bits from miso; divider, mode and bit order latched per transfer.
//
// state | meaning
// IDLE  | cs_n high, sck follows cpol input, waiting for start
// LEAD  | cs_n low, one half-period of setup before the first sck edge
// SHIFT | sck toggles on every tick, 2*WIDTH edges
// TRAIL | one half-period of cs hold, then done
module spi_master_xfer
    import spi_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DIV_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WIDTH-1:0]    tx_data,
    input  logic [DIV_BITS-1:0] div,
    input  logic                cpol,
    input  logic                cpha,
    input  logic                lsb_first,
    input  logic                miso,
    output logic                sck,
    output logic                cs_n,
    output logic                mosi,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    rx_data
);

    localparam int EDGES = 2 * WIDTH;
    localparam int EW    = $clog2(EDGES) + 1;

    spi_state_t          state, state_nx;
    logic [DIV_BITS-1:0] div_q;
    logic                cpol_q, cpha_q, lsb_q;
    logic [WIDTH-1:0]    tx_sh, rx_sh;
    logic [EW-1:0]       edge_cnt;

    logic                tick, accept, tick_shift, last_edge;
    logic                sample_en, shift_en, finish;

    spi_clk_div #(.DIV_BITS(DIV_BITS)) u_clk_div (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .en    (state != IDLE),
        .div   ((state == IDLE) ? div : div_q),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)             state_nx = LEAD;
            LEAD:    if (tick)              state_nx = SHIFT;
            SHIFT:   if (tick && last_edge) state_nx = TRAIL;
            TRAIL:   if (tick)              state_nx = IDLE;
            default:                        state_nx = IDLE;
        endcase
    end

    // Edge parity vs. cpha picks sample or shift: the edge being made is edge_cnt+1.
    always_comb begin
        accept     = (state == IDLE) && start;
        tick_shift = (state == SHIFT) && tick;
        last_edge  = (edge_cnt == EW'(EDGES - 1));
        sample_en  = tick_shift && (edge_cnt[0] == cpha_q);
        shift_en   = tick_shift && (edge_cnt[0] != cpha_q) && !last_edge;
        finish     = (state == TRAIL) && tick;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sck      <= 1'b0;
            cs_n     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
            div_q    <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            edge_cnt <= '0;
        end else begin
            done <= finish;
            if (accept) begin
                div_q    <= div;
                cpol_q   <= cpol;
                cpha_q   <= cpha;
                lsb_q    <= lsb_first;
                cs_n     <= 1'b0;
                busy     <= 1'b1;
                edge_cnt <= '0;
                sck      <= cpol;
            end else if (state == IDLE) begin
                sck <= cpol;
            end
            if (tick_shift) begin
                sck      <= ~sck;
                edge_cnt <= edge_cnt + EW'(1);
            end
            if (finish) begin
                cs_n    <= 1'b1;
                busy    <= 1'b0;
                rx_data <= rx_sh;
            end
        end
    end

    // With cpha=0 the first bit leaves at accept, so tx_sh starts pre-shifted.
    always_ff @(posedge clk) begin
        if (reset) begin
            mosi  <= 1'b0;
            tx_sh <= '0;
            rx_sh <= '0;
        end else begin
            if (accept) begin
                rx_sh <= '0;
                if (!cpha) begin
                    mosi  <= lsb_first ? tx_data[0] : tx_data[WIDTH-1];
                    tx_sh <= lsb_first ? (tx_data >> 1) : (tx_data << 1);
                end else begin
                    tx_sh <= tx_data;
                end
            end
            if (shift_en) begin
                mosi  <= lsb_q ? tx_sh[0] : tx_sh[WIDTH-1];
                tx_sh <= lsb_q ? (tx_sh >> 1) : (tx_sh << 1);
            end
            if (sample_en) begin
                rx_sh <= lsb_q ? {miso, rx_sh[WIDTH-1:1]} : {rx_sh[WIDTH-2:0], miso};
            end
        end
    end

endmodule

// File: tb/tb_spi_master_xfer.sv
// Scoreboard bench for spi_master_xfer: slave model on the bus, expectations queued at accept.
module tb_spi_master_xfer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] tx_data;
    logic [3:0] div;
    logic       cpol, cpha, lsb_first;
    logic       miso;
    logic       sck, cs_n, mosi, busy, done;
    logic [7:0] rx_data;

    logic       start4;
    logic       sck4, cs_n4, mosi4, busy4, done4;
    logic [3:0] rx_data4;

    always #5 clk = ~clk;

    spi_master_xfer #(.WIDTH(8), .DIV_BITS(4)) u_dut (
        .clk(clk), .reset(reset), .start(start), .tx_data(tx_data), .div(div),
        .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .miso(miso),
        .sck(sck), .cs_n(cs_n), .mosi(mosi), .busy(busy), .done(done), .rx_data(rx_data)
    );

    spi_master_xfer #(.WIDTH(4), .DIV_BITS(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .tx_data(4'h9), .div(4'd0),
        .cpol(1'b0), .cpha(1'b0), .lsb_first(1'b0), .miso(mosi4),
        .sck(sck4), .cs_n(cs_n4), .mosi(mosi4), .busy(busy4), .done(done4), .rx_data(rx_data4)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Slave model: drives miso from sl_word, captures mosi on its sampling edges.
    logic       cur_cpol = 1'b0, cur_cpha = 1'b0, cur_lsb = 1'b0, loop_en = 1'b1;
    logic [7:0] sl_word  = 8'h00;
    logic [7:0] sl_rx    = 8'h00;
    int         sl_edges = 0;
    int         lead_cnt = 0;
    time        t_lead0  = 0, t_lead1 = 0;
    logic       sck_prev = 1'b0, cs_prev = 1'b1;
    logic       leading;
    int         idx;
    logic [2:0] bi;

    always @(sck, cs_n) begin
        if (cs_prev === 1'b1 && cs_n === 1'b0) begin
            sl_edges = 0;
            sl_rx    = 8'h00;
            lead_cnt = 0;
        end else if (cs_n === 1'b0 && sck !== sck_prev) begin
            sl_edges++;
            leading = (sck != cur_cpol);
            if (leading) begin
                if (lead_cnt == 0)      t_lead0 = $time;
                else if (lead_cnt == 1) t_lead1 = $time;
                lead_cnt++;
            end
            if (leading == !cur_cpha)
                sl_rx = cur_lsb ? {mosi, sl_rx[7:1]} : {sl_rx[6:0], mosi};
        end
        sck_prev = sck;
        cs_prev  = cs_n;
    end

    always_comb begin
        idx = 0;
        bi  = 3'd0;
        if (cur_cpha) idx = (sl_edges == 0) ? 0 : (sl_edges - 1) / 2;
        else          idx = sl_edges / 2;
        if (idx > 7) idx = 7;
        bi   = cur_lsb ? idx[2:0] : 3'(7 - idx);
        miso = loop_en ? mosi : sl_word[bi];
    end

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
        int         start_cyc;
        int         d;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    always @(negedge clk) begin
        if (reset === 1'b0 && done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'(done), 32'(0));
            end else begin
                e = sb.pop_front();
                chk("rx_data",    32'(rx_data),            32'(e.rx));
                chk("latency",    32'(cyc - e.start_cyc),  32'(18 * (e.d + 1)));
                chk("slave_rx",   32'(sl_rx),              32'(e.tx));
                chk("lead_edges", 32'(lead_cnt),           32'(8));
                chk("sck_period", 32'(t_lead1 - t_lead0),  32'(2 * (e.d + 1) * 10));
                chk("busy_done",  32'(busy),               32'(0));
            end
        end
    end

    task automatic xfer(input logic [7:0] tx, input logic [3:0] d, input logic [1:0] mode,
                        input logic lsb, input logic [7:0] word, input logic lb,
                        input logic [7:0] exp_rx, input bit push, input bit hold, output int n);
        @(negedge clk);
        cpol = mode[1]; cpha = mode[0]; lsb_first = lsb; div = d; tx_data = tx;
        cur_cpol = mode[1]; cur_cpha = mode[0]; cur_lsb = lsb; sl_word = word; loop_en = lb;
        @(negedge clk);
        chk("sck_idle", 32'(sck), 32'(mode[1]));
        start = 1'b1;
        @(posedge clk);
        #1;
        n = cyc;
        if (push) sb.push_back('{tx, exp_rx, n, int'(d)});
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        for (int k = 0; k < 200 && cyc < target; k++) @(negedge clk);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        chk("drain", 32'(sb.size()), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        logic [7:0] rt;
        reset = 1'b1; start = 1'b0; start4 = 1'b0; tx_data = 8'h00; div = 4'd0;
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_sck",     32'(sck),     32'(0));
        chk("rst_cs_n",    32'(cs_n),    32'(1));
        chk("rst_mosi",    32'(mosi),    32'(0));
        chk("rst_busy",    32'(busy),    32'(0));
        chk("rst_done",    32'(done),    32'(0));
        chk("rst_rx_data", 32'(rx_data), 32'(0));

        // mode 0, fastest clock, loopback
        xfer(8'hA5, 4'd0, 2'b00, 1'b0, 8'h00, 1'b1, 8'hA5, 1, 0, n);
        wait_drain();

        // mode 3, div=3, slave returns 0x3C
        xfer(8'h96, 4'd3, 2'b11, 1'b0, 8'h3C, 1'b0, 8'h3C, 1, 0, n);
        wait_drain();

        // mode 1, LSB first
        xfer(8'h01, 4'd2, 2'b01, 1'b1, 8'h80, 1'b0, 8'h80, 1, 0, n);
        wait_drain();

        // starts during an active transfer are ignored
        xfer(8'hC3, 4'd3, 2'b00, 1'b0, 8'h00, 1'b1, 8'hC3, 1, 0, n);
        wait_cyc(n + 3);
        chk("busy_mid", 32'(busy), 32'(1));
        start = 1'b1; tx_data = 8'hFF; div = 4'd0; cpol = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_cyc(n + 10);
        start = 1'b1;
        @(negedge clk); start = 1'b0; cpol = 1'b0;
        wait_drain();

        // start held through the done cycle: back-to-back transfer
        xfer(8'h6E, 4'd1, 2'b10, 1'b0, 8'h00, 1'b1, 8'h6E, 1, 1, n);
        sb.push_back('{8'h17, 8'h17, n + 36 + 1, 1});
        wait_cyc(n + 5);
        tx_data = 8'h17;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (done) break;
        end
        chk("b2b_done_seen", 32'(done), 32'(1));
        chk("b2b_cs_high",   32'(cs_n), 32'(1));
        @(negedge clk);
        #1;
        chk("b2b_cs_low",    32'(cs_n), 32'(0));
        start = 1'b0;
        wait_drain();

        // reset in the middle of a div=1 transfer
        xfer(8'h33, 4'd1, 2'b00, 1'b0, 8'h00, 1'b1, 8'h33, 0, 0, n);
        wait_cyc(n + 7);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_cs_n",    32'(cs_n),    32'(1));
        chk("abort_sck",     32'(sck),     32'(0));
        chk("abort_busy",    32'(busy),    32'(0));
        chk("abort_rx_data", 32'(rx_data), 32'(0));
        chk("abort_mosi",    32'(mosi),    32'(0));
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_idle",    32'(busy),    32'(0));

        // normal operation after the abort, then each mode with random data
        xfer(8'h4B, 4'd1, 2'b00, 1'b0, 8'h00, 1'b1, 8'h4B, 1, 0, n);
        wait_drain();
        for (int i = 0; i < 4; i++) begin
            rt = 8'($urandom);
            xfer(rt, 4'($urandom_range(0, 2)), 2'(i), 1'($urandom), 8'h00, 1'b1, rt, 1, 0, n);
            wait_drain();
        end

        // 4-bit build, loopback
        @(negedge clk);
        start4 = 1'b1;
        @(posedge clk);
        #1;
        n = cyc;
        @(negedge clk);
        start4 = 1'b0;
        for (k = 0; k < 50; k++) begin
            if (done4) break;
            @(negedge clk);
        end
        chk("w4_done",    32'(done4),    32'(1));
        chk("w4_latency", 32'(cyc - n),  32'(10));
        chk("w4_rx_data", 32'(rx_data4), 32'(9));

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
